wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter MD_DEPTH, default 2, giving the MUL/DIV result FIFO depth in entries (minimum 2).
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 4, giving the number of consecutive ALU grants tolerated while a MUL/DIV result waits.
REQ-003 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 alu_valid_i  input  1  ALU result present this cycle.
REQ-006 alu_ready_o  output  1  ALU result accepted when alu_valid_i and alu_ready_o are both 1.
REQ-007 alu_rd_i  input  5  ALU destination register index.
REQ-008 alu_data_i  input  32  ALU result value.
REQ-009 md_valid_i  input  1  MUL/DIV result present this cycle.
REQ-010 md_ready_o  output  1  MUL/DIV result accepted when md_valid_i and md_ready_o are both 1.
REQ-011 md_rd_i  input  5  MUL/DIV destination register index.
REQ-012 md_data_i  input  32  MUL/DIV result value.
REQ-013 md_pending_o  output  1  1 while the MUL/DIV FIFO holds at least one entry.
REQ-014 rd_we_o  output  1  register file write enable.
REQ-015 rd_addr_o  output  5  register file write index.
REQ-016 rd_data_o  output  32  register file write data.

Function
REQ-017 MUL/DIV results SHALL enter a MD_DEPTH-entry FIFO; md_ready_o = (count < MD_DEPTH), computed from current state only, with no same-cycle pop bypass.
REQ-018 The FIFO SHALL preserve acceptance order; a push and a pop in the same cycle SHALL leave count unchanged; pointers SHALL wrap modulo MD_DEPTH.
REQ-019 Each cycle, grant SHALL go to MD (the FIFO head) when the FIFO is non-empty and either alu_valid_i = 0 or starve_cnt = STARVE_LIMIT; otherwise grant SHALL go to ALU when alu_valid_i = 1; otherwise there is no grant.
REQ-020 alu_ready_o SHALL be 0 only when the FIFO is non-empty and starve_cnt = STARVE_LIMIT; otherwise it SHALL be 1.
REQ-021 starve_cnt SHALL increment, saturating at STARVE_LIMIT, on each ALU grant while the FIFO is non-empty, and SHALL clear on an MD grant or whenever the FIFO is empty.
REQ-022 The granted result SHALL be registered into the output stage: in the next cycle rd_addr_o and rd_data_o equal the granted rd and data, and rd_we_o = 1 iff rd != 0.
REQ-023 A granted result with rd = 0 SHALL be consumed (handshake or FIFO pop completes) and rd_we_o SHALL stay 0.
REQ-024 With no grant, rd_we_o SHALL be 0 in the next cycle and rd_addr_o and rd_data_o SHALL hold their values.
REQ-025 ALU latency SHALL be exactly 1 cycle: accepted at cycle N, written at N+1.
REQ-026 MUL/DIV latency SHALL be at least 2 cycles: pushed at cycle N, earliest pop at N+1, write at N+2.
REQ-027 At most one register file write SHALL occur per cycle; no result SHALL be dropped or duplicated.

Reset
REQ-028 While rst_i = 1: rd_we_o = 0, rd_addr_o = 0, rd_data_o = 0, FIFO empty, starve_cnt = 0, md_pending_o = 0, md_ready_o = 1, alu_ready_o = 1.
REQ-029 Asserting rst_i mid-operation SHALL immediately discard FIFO contents and suppress any in-flight write; the first write may occur no earlier than the second rising edge after rst_i deasserts.

Verification
REQ-030 ALU only: alu_valid_i = 1, rd = 5, data = 0xDEADBEEF at cycle N -> rd_we_o = 1, rd_addr_o = 5, rd_data_o = 0xDEADBEEF at N+1; alu_ready_o stays 1.
REQ-031 x0 drop: ALU result rd = 0, data = 0x1234 -> handshake completes and rd_we_o stays 0; the following ALU rd = 3 is written normally.
REQ-032 Starvation: MD rd = 7 pushed at cycle N while ALU is valid every cycle -> 4 ALU writes, then alu_ready_o = 0 for one cycle and MD rd = 7 is written; starve_cnt returns to 0.
REQ-033 FIFO full: 3 back-to-back MD pushes with ALU continuously valid -> md_ready_o = 0 after the 2nd push; the 3rd push stalls until a pop; the write order is MD1, MD2, MD3.
REQ-034 Collision-free idle: MD push with alu_valid_i = 0 -> MD is written at N+2; md_pending_o is 1 at N+1 and 0 at N+2.
REQ-035 Mid-operation reset: FIFO holds 2 entries and rst_i pulses -> all outputs return to REQ-028 values and no stale MD write appears afterward.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Writeback bus bundle: ALU and MUL/DIV result sources into one register file write port.
interface wb_arbiter_if;
  logic        alu_valid_i;
  logic        alu_ready_o;
  logic [4:0]  alu_rd_i;
  logic [31:0] alu_data_i;
  logic        md_valid_i;
  logic        md_ready_o;
  logic [4:0]  md_rd_i;
  logic [31:0] md_data_i;
  logic        md_pending_o;
  logic        rd_we_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;

  modport slave (
    input  alu_valid_i, alu_rd_i, alu_data_i, md_valid_i, md_rd_i, md_data_i,
    output alu_ready_o, md_ready_o, md_pending_o, rd_we_o, rd_addr_o, rd_data_o
  );

  modport master (
    output alu_valid_i, alu_rd_i, alu_data_i, md_valid_i, md_rd_i, md_data_i,
    input  alu_ready_o, md_ready_o, md_pending_o, rd_we_o, rd_addr_o, rd_data_o
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU has priority, MUL/DIV results queue in a small FIFO and
// win after STARVE_LIMIT consecutive ALU grants. One registered write per cycle.
module wb_arbiter #(
  parameter int MD_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic         clk_i,
  input logic         rst_i,
  wb_arbiter_if.slave bus
);
  localparam int PW = (MD_DEPTH > 1) ? $clog2(MD_DEPTH) : 1;
  localparam int CW = $clog2(MD_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_ent_t;

  wb_ent_t         mem [MD_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [SW-1:0]   starve_cnt;
  logic            empty, starved;
  logic            push, pop, grant_alu, grant;
  wb_ent_t         win;
  logic            rd_we_q;
  logic [4:0]      rd_addr_q;
  logic [31:0]     rd_data_q;

  assign empty   = (count == '0);
  assign starved = (starve_cnt == SW'(STARVE_LIMIT));

  // MD wins when ALU is idle or has used up its starvation allowance.
  assign pop       = !empty && (!bus.alu_valid_i || starved);
  assign grant_alu = !pop && bus.alu_valid_i;
  assign grant     = pop || grant_alu;
  assign push      = bus.md_valid_i && bus.md_ready_o;

  assign bus.md_ready_o   = (count < CW'(MD_DEPTH));
  assign bus.alu_ready_o  = !(!empty && starved);
  assign bus.md_pending_o = !empty;
  assign bus.rd_we_o      = rd_we_q;
  assign bus.rd_addr_o    = rd_addr_q;
  assign bus.rd_data_o    = rd_data_q;

  always_comb begin
    win = wb_ent_t'{rd: bus.alu_rd_i, data: bus.alu_data_i};
    if (pop) win = mem[rd_ptr];
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= wb_ent_t'{rd: bus.md_rd_i, data: bus.md_data_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(MD_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(MD_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                 starve_cnt <= '0;
    else if (empty || pop)     starve_cnt <= '0;
    else if (grant_alu && !starved) starve_cnt <= starve_cnt + SW'(1);
  end

  // x0 results are consumed like any other but never raise the write enable.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_we_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else if (grant) begin
      rd_we_q   <= |win.rd;
      rd_addr_q <= win.rd;
      rd_data_q <= win.data;
    end else begin
      rd_we_q   <= 1'b0;
    end
  end
endmodule
